led_breath_sched: RTL
=====================

LED_BREATH_SCHED -- requirements
Module: led_breath_sched

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous, active-high reset.
REQ-002 Parameter HALF_P0, default 15000000, half breathing period in clocks at lever 00.
REQ-003 Parameter HALF_P1, default 25000000, half period at lever 01.
REQ-004 Parameter HALF_P2, default 35000000, half period at lever 10.
REQ-005 Parameter HALF_P3, default 50000000, half period at lever 11.
REQ-006 Parameter DEBOUNCE_CYCLES, default 1000000, stable-level clocks required to accept a button change.
REQ-007 Parameter CYCLES_PER_CH, default 2, full breathing cycles per LED in rotate mode (≥1).
REQ-008 clk  in  1  system clock, 50 MHz.
REQ-009 rst  in  1  synchronous active-high reset.
REQ-010 btn_mode  in  1  asynchronous mode button, active-high.
REQ-011 btn_speed  in  1  asynchronous speed button, active-high.
REQ-012 light_lever  out  2  speed select for the shared breathing-light datapath.
REQ-013 led_mask  out  4  LEDs gated by the shared breathing output, bit i = LED i.
REQ-014 mode  out  2  current mode: 00 OFF, 01 SINGLE, 10 ROTATE, 11 ALL.
REQ-015 breath_restart  out  1  one-clock pulse telling the datapath to restart at phase zero.
REQ-016 cycle_tick  out  1  one-clock pulse at the end of each full breathing cycle.

Function
REQ-017 Each button SHALL pass through a 2-FF synchronizer, then a debouncer that updates its level only after DEBOUNCE_CYCLES consecutive equal samples.
REQ-018 A debounced 0->1 transition SHALL produce a one-clock press pulse; release and bounces shorter than DEBOUNCE_CYCLES SHALL produce none.
REQ-019 A speed press SHALL increment light_lever modulo 4 (11->00).
REQ-020 A mode press SHALL advance the FSM OFF->SINGLE->ROTATE->ALL->OFF.
REQ-021 Channel index ch (2 bits) SHALL be cleared to 0 on entering OFF or ROTATE and SHALL hold in SINGLE and ALL.
REQ-022 led_mask SHALL be 0000 in OFF, one-hot(ch) in SINGLE and ROTATE, and 1111 in ALL.
REQ-023 All outputs SHALL be registered; a press pulse in cycle t SHALL update mode, light_lever and led_mask at t+1.
REQ-024 breath_restart SHALL be asserted at t+1 for any press and for any channel rotation.
REQ-025 Simultaneous events in one cycle SHALL yield a single breath_restart pulse.
REQ-026 Period timer SHALL count 0 .. 2*HALF_P[light_lever]-1 and then wrap to 0; the timer SHALL be at least 32 bits wide with no overflow for the default parameters.
REQ-027 cycle_tick SHALL pulse in the cycle the timer wraps; a cycle counter SHALL count wraps 0 .. CYCLES_PER_CH-1.
REQ-028 In ROTATE, the wrap that completes CYCLES_PER_CH cycles SHALL advance ch modulo 4 (3->0) on the next clock, together with breath_restart, and SHALL clear the cycle counter.
REQ-029 On every breath_restart, the timer and cycle counter SHALL be 0 in that same cycle, so counting restarts from that cycle.
REQ-030 The timer SHALL run in all modes; cycle_tick SHALL also pulse in OFF, SINGLE and ALL, but ch SHALL change only in ROTATE.
REQ-031 A speed press and a mode press in the same cycle SHALL both be applied.

Reset
REQ-032 While rst is high at a clock edge, the block SHALL set mode=00, light_lever=01, led_mask=0000, ch=0, breath_restart=0, cycle_tick=0 and clear the timer and cycle counter.
REQ-033 Reset SHALL set the synchronizers and debounced levels to 0, so a button held through reset produces exactly one press after release of reset plus debounce.
REQ-034 Reset asserted mid-rotation SHALL take priority over any same-cycle press or wrap.

Verification (bench params: HALF_P0..3 = 4,6,8,10; DEBOUNCE_CYCLES=3; CYCLES_PER_CH=2)
REQ-035 Reset: hold rst 2 clocks -> mode=00, led_mask=0000, light_lever=01, breath_restart=0.
REQ-036 Debounce: btn_mode high 2 clocks -> no change; btn_mode held 10 clocks -> mode=01, led_mask=0001, exactly one breath_restart.
REQ-037 Rotation: set light_lever=00, enter ROTATE -> cycle_tick every 8 clocks; led_mask 0001->0010->0100->1000->0001, each step 16 clocks after the previous restart.
REQ-038 Speed mid-cycle: timer at 5 in lever 01, speed press -> light_lever=10, breath_restart pulse, next cycle_tick 16 clocks later.
REQ-039 Simultaneous presses in SINGLE at lever 11 -> mode=10, light_lever=00, led_mask=0001, one breath_restart.
REQ-040 Reset during ROTATE with led_mask=0100 coinciding with a wrap -> all reset values (REQ-032), no rotation.

Source files
------------

// File: rtl/led_breath_sched.sv
// rtl/led_breath_sched.sv - breathing-LED mode/speed scheduler with debounced buttons
// Drives lever, LED mask and restart/tick pulses for a shared breathing-light datapath.
module led_breath_sched #(
  parameter int unsigned HALF_P0         = 15000000,
  parameter int unsigned HALF_P1         = 25000000,
  parameter int unsigned HALF_P2         = 35000000,
  parameter int unsigned HALF_P3         = 50000000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CYCLES_PER_CH   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_speed,
  output logic [1:0] light_lever,
  output logic [3:0] led_mask,
  output logic [1:0] mode,
  output logic       breath_restart,
  output logic       cycle_tick
);

  localparam int unsigned DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned CW  = (CYCLES_PER_CH > 1) ? $clog2(CYCLES_PER_CH) : 1;
  localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]  CYC_LAST = CW'(CYCLES_PER_CH - 1);

  typedef enum logic [1:0] {
    S_OFF    = 2'b00,
    S_SINGLE = 2'b01,
    S_ROTATE = 2'b10,
    S_ALL    = 2'b11
  } state_t;

  state_t          state, state_next;
  logic [1:0]      btn, sync1, sync2, db_level, db_prev, press;
  logic [DBW-1:0]  db_cnt [2];
  logic [1:0]      ch, ch_next, lever_next;
  logic [3:0]      mask_next;
  logic            restart_next, tick_next, wrap, rotate;
  logic [31:0]     timer, timer_next, half_sel, period_last;
  logic [CW-1:0]   cyc, cyc_next;

  assign btn = {btn_speed, btn_mode};

  // Bit 0 is the mode button, bit 1 the speed button.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= '0;
      sync2     <= '0;
      db_level  <= '0;
      db_prev   <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      db_prev <= db_level;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_level[i] <= sync2[i];
          db_cnt[i]   <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  assign press = db_level & ~db_prev;

  always_comb begin
    case (light_lever)
      2'd0:    half_sel = HALF_P0;
      2'd1:    half_sel = HALF_P1;
      2'd2:    half_sel = HALF_P2;
      default: half_sel = HALF_P3;
    endcase
    period_last = {half_sel[30:0], 1'b0} - 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_OFF;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    lever_next   = light_lever;
    ch_next      = ch;
    restart_next = 1'b0;
    tick_next    = 1'b0;
    timer_next   = timer + 32'd1;
    cyc_next     = cyc;
    // >= keeps the timer bounded even if it were ever past the end of a period.
    wrap         = (timer >= period_last);
    rotate       = wrap && (state == S_ROTATE) && (cyc == CYC_LAST);

    if (wrap) begin
      timer_next = '0;
      tick_next  = 1'b1;
      cyc_next   = (cyc == CYC_LAST) ? '0 : cyc + CW'(1);
    end
    if (rotate) begin
      ch_next      = ch + 2'd1;
      restart_next = 1'b1;
    end
    if (press[1]) begin
      lever_next   = light_lever + 2'd1;
      restart_next = 1'b1;
    end
    if (press[0]) begin
      restart_next = 1'b1;
      case (state)
        S_OFF:    state_next = S_SINGLE;
        S_SINGLE: begin
          state_next = S_ROTATE;
          ch_next    = 2'd0;
        end
        S_ROTATE: state_next = S_ALL;
        default: begin
          state_next = S_OFF;
          ch_next    = 2'd0;
        end
      endcase
    end
    // Any restart realigns the period so the datapath and timer start together.
    if (restart_next) begin
      timer_next = '0;
      cyc_next   = '0;
    end

    case (state_next)
      S_OFF:   mask_next = 4'b0000;
      S_ALL:   mask_next = 4'b1111;
      default: mask_next = 4'b0001 << ch_next;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      light_lever    <= 2'b01;
      ch             <= 2'd0;
      led_mask       <= 4'b0000;
      breath_restart <= 1'b0;
      cycle_tick     <= 1'b0;
      timer          <= '0;
      cyc            <= '0;
    end else begin
      light_lever    <= lever_next;
      ch             <= ch_next;
      led_mask       <= mask_next;
      breath_restart <= restart_next;
      cycle_tick     <= tick_next;
      timer          <= timer_next;
      cyc            <= cyc_next;
    end
  end

  assign mode = state;

endmodule
